// File: rtl/btb_pkg.sv
// Shared types for the BTB update controller: FSM states, PC width and
// the update-queue entry layout.
package btb_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } btb_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update queue for BTB writes. Supports push, pop, a whole-queue
// clear and an in-place overwrite of the newest entry's target.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     ovr,
    input  btb_entry_t               wr_entry,
    input  logic [PC_W-1:0]          ovr_target,
    output btb_entry_t               head,
    output logic [PC_W-1:0]          tail_pc,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    btb_entry_t      mem_q [DEPTH];
    btb_entry_t      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   tail_idx;

    assign tail_idx = wr_ptr_q - AW'(1);
    assign head     = mem_q[rd_ptr_q];
    assign tail_pc  = mem_q[tail_idx].pc;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // Next pointer/count/storage values; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ovr) begin
                mem_d[tail_idx].target = ovr_target;
            end
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Pointer/count registers reset; entry storage needs no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: filters resolved branches from EX, coalesces
// repeated updates to the queue tail, drains the queue into one-cycle BTB
// write strobes and sequences whole-BTB clears.
// Optional macro BTB_UPD_FILTER_EN: only mispredicted branches are queued.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_taken,
    input  logic             ex_mispredict,
    input  logic             flush_req,
    output logic             ex_ready,
    output logic             br_update,
    output logic [PC_W-1:0]  pc_ex,
    output logic [PC_W-1:0]  target_pc,
    output logic             btb_clr,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    btb_state_e       state_q, state_d;
    logic             br_update_q, br_update_d;
    logic [PC_W-1:0]  pc_ex_q, pc_ex_d;
    logic [PC_W-1:0]  target_pc_q, target_pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    btb_entry_t       head;
    btb_entry_t       wr_entry;
    logic [PC_W-1:0]  tail_pc;
    logic             full, empty;
    logic [AW:0]      count;

    logic accept, aligned, qualify, eligible, misalign_drop;
    logic pop, tail_leaving, coalesce, push;

`ifdef BTB_UPD_FILTER_EN
    assign qualify = ex_mispredict;
`else
    logic unused_mispredict;
    assign unused_mispredict = ex_mispredict;
    assign qualify = 1'b1;
`endif

    assign ex_ready = ~rst & ~full & (state_q != CLEAR) & ~flush_req;
    assign wr_entry = '{pc: ex_pc, target: ex_target};

    // Classify the incoming report and decide push/pop/coalesce for this cycle
    always_comb begin
        accept        = ex_valid & ex_ready;
        aligned       = (ex_pc[1:0] == 2'b00);
        eligible      = ex_taken & aligned & qualify;
        misalign_drop = accept & ex_taken & ~aligned & qualify;
        pop           = (state_q == DRAIN) & ~flush_req;
        // With a single entry the tail is the head, so it leaves when popped
        tail_leaving  = pop & (count == (AW+1)'(1));
        coalesce      = accept & eligible & ~empty & (tail_pc == ex_pc) & ~tail_leaving;
        push          = accept & eligible & ~coalesce;
    end

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush_req),
        .push       (push),
        .pop        (pop),
        .ovr        (coalesce),
        .wr_entry   (wr_entry),
        .ovr_target (ex_target),
        .head       (head),
        .tail_pc    (tail_pc),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Next-state, registered BTB write outputs and saturating drop counter
    always_comb begin
        state_d     = state_q;
        br_update_d = pop;
        pc_ex_d     = pc_ex_q;
        target_pc_d = target_pc_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            IDLE:    if (push) state_d = DRAIN;
            DRAIN:   if (tail_leaving && !push) state_d = IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_req) begin
            state_d = CLEAR;
        end

        if (pop) begin
            pc_ex_d     = head.pc;
            target_pc_d = head.target;
        end

        if (misalign_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            br_update_q <= 1'b0;
            pc_ex_q     <= '0;
            target_pc_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            br_update_q <= br_update_d;
            pc_ex_q     <= pc_ex_d;
            target_pc_q <= target_pc_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign br_update = br_update_q;
    assign pc_ex     = pc_ex_q;
    assign target_pc = target_pc_q;
    assign drop_cnt  = drop_cnt_q;
    assign btb_clr   = rst | (state_q == CLEAR);
    assign busy      = ~rst & (~empty | (state_q != IDLE));

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a queue-based reference model
// predicts every BTB write, which a monitor checks as the DUT emits it.
module tb_btb_update_ctrl;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ex_valid = 1'b0;
    logic [31:0]       ex_pc = '0;
    logic [31:0]       ex_target = '0;
    logic              ex_taken = 1'b0;
    logic              ex_mispredict = 1'b0;
    logic              flush_req = 1'b0;
    logic              ex_ready;
    logic              br_update;
    logic [31:0]       pc_ex;
    logic [31:0]       target_pc;
    logic              btb_clr;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;

    always #5 clk = ~clk;

    btb_update_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_taken      (ex_taken),
        .ex_mispredict (ex_mispredict),
        .flush_req     (flush_req),
        .ex_ready      (ex_ready),
        .br_update     (br_update),
        .pc_ex         (pc_ex),
        .target_pc     (target_pc),
        .btb_clr       (btb_clr),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } upd_t;

    // reference model state
    upd_t        mq[$];
    upd_t        exp_q[$];
    bit          clearing = 0;
    int          drop_m = 0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_tgt = '0;
    bit          exp_upd_now = 0;
    bit          exp_clr = 0;
    bit          exp_busy = 0;
    bit          m_ready = 0;
    bit          mon_en = 0;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit qualifies(input bit mis);
`ifdef BTB_UPD_FILTER_EN
        return mis;
`else
        return 1'b1;
`endif
    endfunction

    // One clock of stimulus; the model advances to the state after the next edge
    task automatic step(input bit r, input bit fl, input bit v, input bit tk, input bit mis,
                        input logic [31:0] pc, input logic [31:0] tgt, output bit acc);
        bit   elig;
        bit   coal;
        bit   popped;
        upd_t e;
        @(negedge clk);
        rst = r; flush_req = fl; ex_valid = v; ex_taken = tk;
        ex_mispredict = mis; ex_pc = pc; ex_target = tgt;
        exp_upd_now = 0;
        acc = 0;
        if (r) begin
            m_ready = 0;
            mq.delete();
            clearing = 0;
            drop_m = 0;
            last_pc = '0;
            last_tgt = '0;
        end else begin
            m_ready = (mq.size() < DEPTH) && !clearing && !fl;
            acc = v && m_ready;
            if (fl) begin
                mq.delete();
                clearing = 1;
            end else begin
                popped = !clearing && (mq.size() > 0);
                clearing = 0;
                elig = tk && (pc[1:0] == 2'b00) && qualifies(mis);
                coal = 0;
                if (acc && elig && mq.size() > 0) begin
                    coal = (mq[mq.size()-1].pc == pc) && !(popped && mq.size() == 1);
                    if (coal) begin
                        e = mq[mq.size()-1];
                        e.tgt = tgt;
                        mq[mq.size()-1] = e;
                    end
                end
                if (popped) begin
                    e = mq.pop_front();
                    exp_q.push_back(e);
                    exp_upd_now = 1;
                    last_pc = e.pc;
                    last_tgt = e.tgt;
                end
                if (acc && elig && !coal) mq.push_back('{pc: pc, tgt: tgt});
                if (acc && tk && (pc[1:0] != 2'b00) && qualifies(mis) && drop_m < CNT_MAX)
                    drop_m++;
            end
        end
        exp_clr  = r || clearing;
        exp_busy = !r && (mq.size() > 0 || clearing);
        mon_en = 1;
        #1 check("ex_ready", ex_ready, m_ready);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, acc);
    endtask

    // Present a report until accepted, as an EX source honouring ex_ready would
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit mis);
        bit acc;
        int n;
        n = 0;
        do begin
            step(0, 0, 1, tk, mis, pc, tgt, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: report pc=%0h not accepted in %0d cycles", pc, n);
        end
    endtask

    // Monitor: compares outputs after each active edge against the model
    always @(posedge clk) begin
        upd_t e;
        #1;
        if (mon_en) begin
            check("br_update", br_update, exp_upd_now);
            if (br_update) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_unexpected: br_update pc=%0h tgt=%0h, expected none", pc_ex, target_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc_ex, e.pc);
                    check("sb_target", target_pc, e.tgt);
                end
            end
            check("pc_ex", pc_ex, last_pc);
            check("target_pc", target_pc, last_tgt);
            check("drop_cnt", drop_cnt, drop_m);
            check("busy", busy, exp_busy);
            check("btb_clr", btb_clr, exp_clr);
        end
    end

    initial begin
        bit          acc;
        bit          r, fl, v, tk, mis;
        logic [31:0] pc, tgt;
        logic [31:0] bases [4];
        bases[0] = 32'h0000_1000; bases[1] = 32'h0000_2000;
        bases[2] = 32'h0000_1000; bases[3] = 32'h0000_3000;

        // reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 32'h0, 32'h0, acc);
        idle(2);

        // single report
        send(32'h0000_0100, 32'h0000_0400, 1, 1);
        idle(4);

        // five back-to-back distinct reports
        for (int i = 0; i < 5; i++) send(32'h0000_0500 + 32'(i * 16), 32'h0000_9000 + 32'(i * 4), 1, 1);
        idle(6);

        // not-taken reports are accepted and discarded
        send(32'h0000_0600, 32'h0000_0700, 0, 1);
        send(32'h0000_0601, 32'h0000_0700, 0, 0);
        idle(3);

        // misaligned report, then saturation of drop_cnt
        send(32'h0000_0102, 32'h0000_0400, 1, 1);
        idle(2);
        for (int i = 0; i < CNT_MAX + 3; i++) step(0, 0, 1, 1, 1, 32'h0000_0102, 32'h0000_0400, acc);
        idle(1);
        @(posedge clk); #2;
        check("drop_saturated", drop_cnt, 16'hFFFF);

        // same pc twice back-to-back
        send(32'h0000_0200, 32'h0000_0300, 1, 1);
        send(32'h0000_0200, 32'h0000_0380, 1, 1);
        idle(4);

        // flush while reports are in flight, then held flush
        send(32'h0000_0A00, 32'h0000_0B00, 1, 1);
        send(32'h0000_0A10, 32'h0000_0B10, 1, 1);
        send(32'h0000_0A20, 32'h0000_0B20, 1, 1);
        step(0, 1, 1, 1, 1, 32'h0000_0A30, 32'h0000_0B30, acc);
        idle(3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, 32'h0, acc);
        idle(2);

        // reset asserted mid-drain
        send(32'h0000_0C00, 32'h0000_0D00, 1, 1);
        send(32'h0000_0C10, 32'h0000_0D10, 1, 1);
        step(1, 0, 1, 1, 1, 32'h0000_0C20, 32'h0000_0D20, acc);
        idle(3);

`ifdef BTB_UPD_FILTER_EN
        send(32'h0000_0E00, 32'h0000_0F00, 1, 0);
        idle(3);
        send(32'h0000_0E00, 32'h0000_0F00, 1, 1);
        idle(3);
`endif

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 2) != 0);
            tk  = ($urandom_range(0, 3) != 0);
            mis = $urandom_range(0, 1);
            pc  = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 1) * 16);
            if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(1, 3));
            tgt = $urandom;
            step(r, fl, v, tk, mis, pc, tgt, acc);
        end
        idle(8);

        @(posedge clk); #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
